// File: rtl/pc_seq_unit_if.sv
// Bus between the decoder/ALU redirect logic (master) and the PC sequencing unit (slave).
// Multiply handshake: mul acts as valid, mul_ready as ready; the op completes on the edge where both are high.
interface pc_seq_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             mul;
    logic             mul_ready;
    logic [1:0]       jump_signal;
    logic [XLEN-1:0]  jump_addr;
    logic [XLEN-1:0]  read_data;
    logic             call;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic             mul_busy;
    logic             trap;
    logic [XLEN-1:0]  trap_pc;
    logic [CNT_W-1:0] instret;
    logic             ras_empty;
    logic [1:0]       dbg_state;

    modport master (
        output mul, mul_ready, jump_signal, jump_addr, read_data, call,
        input  pc, pc_next, mul_busy, trap, trap_pc, instret, ras_empty, dbg_state
    );

    modport slave (
        input  mul, mul_ready, jump_signal, jump_addr, read_data, call,
        output pc, pc_next, mul_busy, trap, trap_pc, instret, ras_empty, dbg_state
    );
endinterface

// File: rtl/pc_seq_unit.sv
// Registered PC with sequential/relative/indirect/return redirects, multiply stall and sticky trap.
// Define PC_RAS_EN to build the circular return-address stack; otherwise jump_signal 11 is illegal.
module pc_seq_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INST_BYTES   = 4,
    parameter int              CNT_W        = 32,
    parameter int              RAS_DEPTH    = 4
) (
    input logic           clk,
    input logic           rst,
    pc_seq_unit_if.slave  bus
);
    localparam int OFF_W = $clog2(INST_BYTES);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MULWAIT = 2'd1,
        ST_TRAP    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  trap_pc_q, trap_pc_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  seq_pc, target, ras_top;
    logic             fault, ras_none, do_push, do_pop;

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr_q, top_idx;
    logic [PW:0]     ras_cnt_q;

    // ras_ptr_q points at the next free slot; a push onto a full stack overwrites the oldest entry
    assign top_idx  = ras_ptr_q - PW'(1);
    assign ras_top  = ras_mem_q[top_idx];
    assign ras_none = (ras_cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else if (do_push) begin
            ras_ptr_q <= ras_ptr_q + PW'(1);
            if (ras_cnt_q != (PW+1)'(RAS_DEPTH))
                ras_cnt_q <= ras_cnt_q + (PW+1)'(1);
        end else if (do_pop) begin
            ras_ptr_q <= top_idx;
            ras_cnt_q <= ras_cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            ras_mem_q[ras_ptr_q] <= seq_pc;
    end
`else
    logic unused_ras;
    assign ras_top    = '0;
    assign ras_none   = 1'b1;
    assign unused_ras = ^{bus.call, do_push, do_pop};
`endif

    logic unused_rd0;
    assign unused_rd0 = bus.read_data[0];

    // Redirect target and fault detection; an empty/absent stack makes a return a fault
    always_comb begin
        seq_pc = pc_q + XLEN'(INST_BYTES);
        target = seq_pc;
        fault  = 1'b0;
        case (bus.jump_signal)
            2'b00:   target = seq_pc;
            2'b01:   target = pc_q + bus.jump_addr;
            2'b10:   target = {bus.read_data[XLEN-1:1], 1'b0};
            default: begin
                target = ras_top;
                fault  = ras_none;
            end
        endcase
        if (target[OFF_W-1:0] != '0)
            fault = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VECTOR;
            trap_q    <= 1'b0;
            trap_pc_q <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            trap_q    <= trap_d;
            trap_pc_q <= trap_pc_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.mul) begin
                    if (!bus.mul_ready)
                        state_d = ST_MULWAIT;
                end else if (fault) begin
                    state_d = ST_TRAP;
                end
            end
            ST_MULWAIT: if (bus.mul_ready) state_d = ST_RUN;
            default:    state_d = ST_TRAP;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        trap_d    = trap_q;
        trap_pc_d = trap_pc_q;
        do_push   = 1'b0;
        do_pop    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.mul) begin
                    if (bus.mul_ready)
                        pc_d = seq_pc;
                end else if (fault) begin
                    trap_d    = 1'b1;
                    trap_pc_d = pc_q;
                end else begin
                    pc_d    = target;
                    do_pop  = (bus.jump_signal == 2'b11);
                    do_push = bus.call && (bus.jump_signal == 2'b01 || bus.jump_signal == 2'b10);
                end
            end
            ST_MULWAIT: if (bus.mul_ready) pc_d = seq_pc;
            default: ;
        endcase
        // A redirect that lands on the current pc is not an advance
        instret_d = (pc_d != pc_q) ? instret_q + CNT_W'(1) : instret_q;
    end

    assign bus.pc        = pc_q;
    assign bus.pc_next   = rst ? RESET_VECTOR : pc_d;
    assign bus.mul_busy  = (state_q == ST_MULWAIT);
    assign bus.trap      = trap_q;
    assign bus.trap_pc   = trap_pc_q;
    assign bus.instret   = instret_q;
    assign bus.ras_empty = ras_none;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed scenarios plus random traffic against a queue-based model.
// Build with PC_RAS_EN defined to exercise the return-address stack scenario.
module tb_pc_seq_unit;
    localparam int          XLEN  = 32;
    localparam logic [31:0] RV    = 32'h100;
    localparam int          IB    = 4;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_seq_unit_if #(.XLEN(XLEN), .CNT_W(32)) bus ();

    pc_seq_unit #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .INST_BYTES(IB), .CNT_W(32), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] m_pc = '0, m_trap_pc = '0, m_instret = '0;
    bit          m_wait = 0, m_trap = 0;
    logic [31:0] m_ras[$];
    logic [31:0] n_pc, n_trap_pc, n_instret;
    bit          n_wait, n_trap;
    logic [31:0] n_ras[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit mul, input bit rdy, input logic [1:0] js,
                         input logic [31:0] ja, input logic [31:0] rd, input bit call);
        bus.mul = mul; bus.mul_ready = rdy; bus.jump_signal = js;
        bus.jump_addr = ja; bus.read_data = rd; bus.call = call;
    endtask

    task automatic predict();
        logic [31:0] tgt;
        bit bad;
        n_pc = m_pc; n_wait = m_wait; n_trap = m_trap; n_trap_pc = m_trap_pc;
        n_instret = m_instret; n_ras = m_ras;
        if (rst) begin
            n_pc = RV; n_wait = 0; n_trap = 0; n_trap_pc = '0; n_instret = '0;
            n_ras.delete();
            return;
        end
        if (m_trap) begin
        end else if (m_wait) begin
            if (bus.mul_ready) begin n_pc = m_pc + IB; n_wait = 0; end
        end else if (bus.mul) begin
            if (bus.mul_ready) n_pc = m_pc + IB;
            else               n_wait = 1;
        end else begin
            bad = 0;
            tgt = '0;
            case (bus.jump_signal)
                2'd0: tgt = m_pc + IB;
                2'd1: tgt = m_pc + bus.jump_addr;
                2'd2: tgt = bus.read_data & ~32'h1;
                default: begin
`ifdef PC_RAS_EN
                    if (m_ras.size() == 0) bad = 1;
                    else tgt = m_ras[$];
`else
                    bad = 1;
`endif
                end
            endcase
            if (tgt % IB != 0) bad = 1;
            if (bad) begin
                n_trap = 1; n_trap_pc = m_pc;
            end else begin
                n_pc = tgt;
`ifdef PC_RAS_EN
                if (bus.jump_signal == 2'd3) begin
                    void'(n_ras.pop_back());
                end else if (bus.call && bus.jump_signal != 2'd0) begin
                    n_ras.push_back(m_pc + IB);
                    if (n_ras.size() > DEPTH) void'(n_ras.pop_front());
                end
`endif
            end
        end
        if (n_pc != m_pc) n_instret = m_instret + 1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        predict();
        if (!rst) check({tag, "/pc_next"}, bus.pc_next, n_pc);
        @(posedge clk);
        #1;
        m_pc = n_pc; m_wait = n_wait; m_trap = n_trap; m_trap_pc = n_trap_pc;
        m_instret = n_instret; m_ras = n_ras;
        check({tag, "/pc"}, bus.pc, m_pc);
        check({tag, "/trap"}, bus.trap, m_trap);
        check({tag, "/trap_pc"}, bus.trap_pc, m_trap_pc);
        check({tag, "/instret"}, bus.instret, m_instret);
        check({tag, "/mul_busy"}, bus.mul_busy, m_wait);
`ifdef PC_RAS_EN
        check({tag, "/ras_empty"}, bus.ras_empty, m_ras.size() == 0);
`else
        check({tag, "/ras_empty"}, bus.ras_empty, 1'b1);
`endif
    endtask

    task automatic goto_pc(input logic [31:0] a);
        drive(0, 0, 2'd2, '0, a, 0);
        cycle("goto");
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        drive(0, 0, 2'd0, '0, '0, 0);
        for (int i = 0; i < n; i++) cycle("rst");
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] ir_snap;
        int ja_i;
        int trap_cycles;

        // T1: reset and sequential advance
        do_reset(2);
        check("t1_rst_pc", bus.pc, 32'h100);
        check("t1_rst_instret", bus.instret, 0);
        check("t1_rst_trap", bus.trap, 0);
        check("t1_rst_ras_empty", bus.ras_empty, 1);
        drive(0, 0, 2'd0, '0, '0, 0);
        for (int i = 1; i <= 3; i++) begin
            cycle("t1_seq");
            check("t1_pc", bus.pc, 32'h100 + 32'(4 * i));
        end
        check("t1_instret", bus.instret, 3);

        // T2: multiply stall, redirect request ignored while waiting
        goto_pc(32'h20);
        drive(1, 0, 2'd1, 32'h100, '0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("t2_stall");
            check("t2_pc_hold", bus.pc, 32'h20);
            check("t2_busy", bus.mul_busy, 1);
        end
        drive(1, 1, 2'd1, 32'h100, '0, 0);
        cycle("t2_done");
        check("t2_pc_done", bus.pc, 32'h24);
        check("t2_busy_done", bus.mul_busy, 0);

        // T3: relative, indirect and wrapping redirects
        goto_pc(32'h40);
        drive(0, 0, 2'd1, -32'sd8, '0, 0);
        cycle("t3_rel");
        check("t3_rel_pc", bus.pc, 32'h38);
        drive(0, 0, 2'd2, '0, 32'h201, 0);
        cycle("t3_ind");
        check("t3_ind_pc", bus.pc, 32'h200);
        goto_pc(32'hFFFF_FFFC);
        drive(0, 0, 2'd1, 32'h8, '0, 0);
        cycle("t3_wrap");
        check("t3_wrap_pc", bus.pc, 32'h4);

        // T4: misaligned target traps and freezes until reset
        goto_pc(32'h50);
        ir_snap = bus.instret;
        drive(0, 0, 2'd1, 32'h2, '0, 0);
        cycle("t4_trap");
        check("t4_pc", bus.pc, 32'h50);
        check("t4_trap", bus.trap, 1);
        check("t4_trap_pc", bus.trap_pc, 32'h50);
        for (int i = 0; i < 3; i++) begin
            drive(i == 1, 1, 2'(i), 32'h40, 32'h80, 1);
            cycle("t4_frozen");
        end
        check("t4_instret_frozen", bus.instret, ir_snap);
        check("t4_pc_frozen", bus.pc, 32'h50);
        do_reset(1);
        check("t4_rst_trap", bus.trap, 0);
        check("t4_rst_pc", bus.pc, 32'h100);

`ifdef PC_RAS_EN
        // T5: five calls overflow a 4-deep stack, four returns, fifth underflows
        goto_pc(32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 2'd1, 32'h100, '0, 1);
            cycle("t5_call");
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 2'd3, '0, '0, 0);
            cycle("t5_ret");
            check("t5_ret_pc", bus.pc, 32'h404 - 32'(32'h100 * i));
        end
        drive(0, 0, 2'd3, '0, '0, 0);
        cycle("t5_underflow");
        check("t5_underflow_trap", bus.trap, 1);
        do_reset(1);
`else
        // T6: return select without a stack is illegal
        goto_pc(32'h10);
        drive(0, 0, 2'd3, '0, '0, 1);
        cycle("t6_illegal");
        check("t6_trap", bus.trap, 1);
        check("t6_trap_pc", bus.trap_pc, 32'h10);
        check("t6_ras_empty", bus.ras_empty, 1);
        do_reset(1);
`endif

        // Random traffic; reset shortly after any trap so the run keeps moving
        trap_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [1:0]  js;
            logic [31:0] ja, rd;
            int sel;
            sel = $urandom_range(0, 9);
            js  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 8) ? 2'd2 : 2'd3;
            ja_i = ($urandom_range(0, 64) - 32) * 4;
            ja = 32'(ja_i);
            if ($urandom_range(0, 9) == 0) ja = ja + 32'($urandom_range(1, 3));
            rd = {$urandom, 2'b00} >> 2 << 2;
            rd = rd | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) rd = $urandom;
            rst = (trap_cycles >= 2) || ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), js, ja, rd,
                  1'($urandom_range(0, 1)));
            cycle("rand");
            trap_cycles = m_trap ? trap_cycles + 1 : 0;
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
